// File: rtl/clock_pkg.sv
// clock_pkg -- shared constants and types for the calendar month/year block.
//   SELECT_*_CODE : default select_item codes that put month / year into edit
//   MONTH_MAX     : last month of the year
//   YEAR_MAX      : last representable year before wrapping to 0
//   month_t/year_t: storage types for month (4 bit) and year (14 bit)
//   step_e        : pending edit step direction
package clock_pkg;

    typedef logic [3:0]  month_t;
    typedef logic [13:0] year_t;

    localparam logic [2:0] SELECT_MONTH_CODE = 3'b100;
    localparam logic [2:0] SELECT_YEAR_CODE  = 3'b101;

    localparam month_t MONTH_MAX = 4'd12;
    localparam year_t  YEAR_MAX  = 14'd9999;

    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_UP   = 2'd1,
        STEP_DOWN = 2'd2
    } step_e;

endpackage

// File: rtl/leap_calc.sv
// leap_calc -- Gregorian leap flag without a divider.
// Keeps year mod 4, mod 100 and mod 400 as residue registers that move in
// lock-step with the year register of the parent.
// Ports:
//   clk_1Hz : clock, rising edge
//   rst_n   : synchronous active-low reset, loads residues of YEAR_RST
//   inc     : year is being incremented by one this edge (no wrap)
//   dec     : year is being decremented by one this edge (no wrap)
//   load    : year is wrapping; year holds the new value (0 or YEAR_MAX)
//   year    : next year value, only inspected on load
//   leap    : leap flag for the current (registered) year
module leap_calc
    import clock_pkg::*;
#(
    parameter year_t YEAR_RST = 14'd2000
) (
    input  logic  clk_1Hz,
    input  logic  rst_n,
    input  logic  inc,
    input  logic  dec,
    input  logic  load,
    input  year_t year,
    output logic  leap
);

    // Residues of constants are folded at elaboration; no runtime divide.
    localparam logic [1:0] R4_RST   = 2'(YEAR_RST % 14'd4);
    localparam logic [6:0] R100_RST = 7'(YEAR_RST % 14'd100);
    localparam logic [8:0] R400_RST = 9'(YEAR_RST % 14'd400);
    localparam logic [1:0] R4_MAX   = 2'(YEAR_MAX % 14'd4);
    localparam logic [6:0] R100_MAX = 7'(YEAR_MAX % 14'd100);
    localparam logic [8:0] R400_MAX = 9'(YEAR_MAX % 14'd400);

    logic [1:0] r4_q;
    logic [6:0] r100_q;
    logic [8:0] r400_q;

    always_ff @(posedge clk_1Hz) begin
        if (!rst_n) begin
            r4_q   <= R4_RST;
            r100_q <= R100_RST;
            r400_q <= R400_RST;
        end else if (load) begin
            // Only the two wrap endpoints are ever loaded.
            if (year == '0) begin
                r4_q   <= '0;
                r100_q <= '0;
                r400_q <= '0;
            end else begin
                r4_q   <= R4_MAX;
                r100_q <= R100_MAX;
                r400_q <= R400_MAX;
            end
        end else if (inc) begin
            r4_q   <= r4_q + 2'd1;
            r100_q <= (r100_q == 7'd99)  ? 7'd0 : r100_q + 7'd1;
            r400_q <= (r400_q == 9'd399) ? 9'd0 : r400_q + 9'd1;
        end else if (dec) begin
            r4_q   <= r4_q - 2'd1;
            r100_q <= (r100_q == 7'd0) ? 7'd99  : r100_q - 7'd1;
            r400_q <= (r400_q == 9'd0) ? 9'd399 : r400_q - 9'd1;
        end
    end

    assign leap = (r4_q == 2'd0) && ((r100_q != 7'd0) || (r400_q == 9'd0));

endmodule

// File: rtl/month_year.sv
// month_year -- month (1..12) and year (0..9999) counter with key editing.
// Counts on the upstream day carry, edits via up/down keys when select_item
// names the month or the year, and flags the 9999->0 rollover.
// Optional feature: define KEY_REPEAT_EN for auto-repeat of held edit keys.
// Ports:
//   clk_1Hz     : clock, rising edge
//   rst_n       : synchronous active-low reset
//   en_1        : count enable
//   carry_in    : day-rollover pulse
//   up, down    : synchronised edit keys (levels)
//   select_item : item under edit
//   month_bin   : registered month 1..12
//   year_bin    : registered year 0..9999
//   leap_year   : leap flag for year_bin
//   carry_out   : one-cycle pulse on count-driven 9999->0 rollover
module month_year
    import clock_pkg::*;
#(
    parameter logic [2:0]  SELECT_MONTH = SELECT_MONTH_CODE,
    parameter logic [2:0]  SELECT_YEAR  = SELECT_YEAR_CODE,
    parameter logic [13:0] YEAR_RST     = 14'd2000
) (
    input  logic        clk_1Hz,
    input  logic        rst_n,
    input  logic        en_1,
    input  logic        carry_in,
    input  logic        up,
    input  logic        down,
    input  logic [2:0]  select_item,
    output logic [3:0]  month_bin,
    output logic [13:0] year_bin,
    output logic        leap_year,
    output logic        carry_out
);

    month_t month_q, month_d;
    year_t  year_q,  year_d;
    logic   carry_q, carry_d;
    logic   up_q, down_q;
    step_e  step_q, step_d;
    logic   step_year_q, step_year_d;

    logic edit_month, edit_year, edit_mode;
    logic up_rise, dn_rise;
    logic req_up, req_dn;
    logic count;
    logic leap_inc, leap_dec, leap_load;

    assign edit_month = (select_item == SELECT_MONTH);
    assign edit_year  = (select_item == SELECT_YEAR);
    assign edit_mode  = edit_month || edit_year;
    assign up_rise    = up   && !up_q;
    assign dn_rise    = down && !down_q;
    assign count      = en_1 && carry_in && !edit_mode;

`ifdef KEY_REPEAT_EN
    logic [1:0] up_cnt_q, up_cnt_d, dn_cnt_q, dn_cnt_d;
    logic       up_arm_q, up_arm_d, dn_arm_q, dn_arm_d;
    logic [2:0] sel_q;
    logic       hold_ok, up_rep, dn_rep;

    // A key is armed by a rising edge accepted in edit mode; while it stays
    // held on the same item the counter saturates at 3 and, once it has
    // seen two held cycles, each further held cycle requests a step.
    always_comb begin
        hold_ok  = edit_mode && (select_item == sel_q);
        up_arm_d = 1'b0;
        up_cnt_d = '0;
        dn_arm_d = 1'b0;
        dn_cnt_d = '0;
        if (edit_mode && up_rise) begin
            up_arm_d = 1'b1;
        end else if (up && up_q && hold_ok && up_arm_q) begin
            up_arm_d = 1'b1;
            up_cnt_d = (up_cnt_q == 2'd3) ? 2'd3 : up_cnt_q + 2'd1;
        end
        if (edit_mode && dn_rise) begin
            dn_arm_d = 1'b1;
        end else if (down && down_q && hold_ok && dn_arm_q) begin
            dn_arm_d = 1'b1;
            dn_cnt_d = (dn_cnt_q == 2'd3) ? 2'd3 : dn_cnt_q + 2'd1;
        end
        up_rep = up   && up_q   && hold_ok && up_arm_q && up_cnt_q[1];
        dn_rep = down && down_q && hold_ok && dn_arm_q && dn_cnt_q[1];
    end

    always_ff @(posedge clk_1Hz) begin
        if (!rst_n) begin
            up_cnt_q <= '0;
            dn_cnt_q <= '0;
            up_arm_q <= 1'b0;
            dn_arm_q <= 1'b0;
            sel_q    <= '0;
        end else begin
            up_cnt_q <= up_cnt_d;
            dn_cnt_q <= dn_cnt_d;
            up_arm_q <= up_arm_d;
            dn_arm_q <= dn_arm_d;
            sel_q    <= select_item;
        end
    end

    assign req_up = (edit_mode && up_rise) || up_rep;
    assign req_dn = (edit_mode && dn_rise) || dn_rep;
`else
    assign req_up = edit_mode && up_rise;
    assign req_dn = edit_mode && dn_rise;
`endif

    always_comb begin
        step_d      = STEP_NONE;
        step_year_d = edit_year;
        if (req_up && !req_dn) begin
            step_d = STEP_UP;
        end else if (req_dn && !req_up) begin
            step_d = STEP_DOWN;
        end

        month_d   = month_q;
        year_d    = year_q;
        carry_d   = 1'b0;
        leap_inc  = 1'b0;
        leap_dec  = 1'b0;
        leap_load = 1'b0;

        // A pending edit step wins over a coincident count step.
        if (step_q != STEP_NONE) begin
            if (step_year_q) begin
                if (step_q == STEP_UP) begin
                    if (year_q == YEAR_MAX) begin
                        year_d    = '0;
                        leap_load = 1'b1;
                    end else begin
                        year_d   = year_q + 14'd1;
                        leap_inc = 1'b1;
                    end
                end else begin
                    if (year_q == '0) begin
                        year_d    = YEAR_MAX;
                        leap_load = 1'b1;
                    end else begin
                        year_d   = year_q - 14'd1;
                        leap_dec = 1'b1;
                    end
                end
            end else begin
                if (step_q == STEP_UP) begin
                    month_d = (month_q == MONTH_MAX) ? 4'd1 : month_q + 4'd1;
                end else begin
                    month_d = (month_q == 4'd1) ? MONTH_MAX : month_q - 4'd1;
                end
            end
        end else if (count) begin
            if (month_q == MONTH_MAX) begin
                month_d = 4'd1;
                if (year_q == YEAR_MAX) begin
                    year_d    = '0;
                    leap_load = 1'b1;
                    carry_d   = 1'b1;
                end else begin
                    year_d   = year_q + 14'd1;
                    leap_inc = 1'b1;
                end
            end else begin
                month_d = month_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk_1Hz) begin
        if (!rst_n) begin
            month_q     <= 4'd1;
            year_q      <= YEAR_RST;
            carry_q     <= 1'b0;
            up_q        <= 1'b0;
            down_q      <= 1'b0;
            step_q      <= STEP_NONE;
            step_year_q <= 1'b0;
        end else begin
            month_q     <= month_d;
            year_q      <= year_d;
            carry_q     <= carry_d;
            up_q        <= up;
            down_q      <= down;
            step_q      <= step_d;
            step_year_q <= step_year_d;
        end
    end

    leap_calc #(
        .YEAR_RST (YEAR_RST)
    ) u_leap (
        .clk_1Hz (clk_1Hz),
        .rst_n   (rst_n),
        .inc     (leap_inc),
        .dec     (leap_dec),
        .load    (leap_load),
        .year    (year_d),
        .leap    (leap_year)
    );

    assign month_bin = month_q;
    assign year_bin  = year_q;
    assign carry_out = carry_q;

endmodule

// File: tb/tb_month_year.sv
// Bench for month_year: table of count vectors plus hand-written edit,
// reset and repeat sequences; expectations go through a timed scoreboard.
module tb_month_year;

    localparam logic [2:0] SEL_M = 3'b100;
    localparam logic [2:0] SEL_Y = 3'b101;
    localparam logic [2:0] SEL_N = 3'b000;

    logic        clk = 1'b0;
    logic        rst_n, en_1, carry_in, up, down;
    logic [2:0]  sel;
    logic [3:0]  month_bin;
    logic [13:0] year_bin;
    logic        leap_year, carry_out;

    always #5 clk = ~clk;

    month_year #(
        .SELECT_MONTH (3'b100),
        .SELECT_YEAR  (3'b101),
        .YEAR_RST     (14'd2000)
    ) dut (
        .clk_1Hz     (clk),
        .rst_n       (rst_n),
        .en_1        (en_1),
        .carry_in    (carry_in),
        .up          (up),
        .down        (down),
        .select_item (sel),
        .month_bin   (month_bin),
        .year_bin    (year_bin),
        .leap_year   (leap_year),
        .carry_out   (carry_out)
    );

    typedef struct {
        string name;
        int    due;
        int    m;
        int    y;
        bit    l;
        bit    c;
    } exp_t;

    typedef struct {
        string name;
        int    m0;
        int    y0;
        int    m1;
        int    y1;
        bit    l1;
        bit    c1;
    } cnt_vec_t;

    exp_t     sb[$];
    exp_t     mon_e;
    cnt_vec_t tbl[6];
    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int cur_m, cur_y;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit leap_of(int y);
        return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
    endfunction

    function automatic void cmp(string n, string f, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s %s: got %0d expected %0d", n, f, got, want);
        end
    endfunction

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            mon_e = sb.pop_front();
            cmp(mon_e.name, "month", int'(month_bin), mon_e.m);
            cmp(mon_e.name, "year",  int'(year_bin),  mon_e.y);
            cmp(mon_e.name, "leap",  int'(leap_year), int'(mon_e.l));
            cmp(mon_e.name, "carry", int'(carry_out), int'(mon_e.c));
        end
    end

    task automatic expect_st(string name, int lat, int m, int y, bit l, bit c);
        exp_t e;
        e.name = name;
        e.due  = cyc + lat;
        e.m    = m;
        e.y    = y;
        e.l    = l;
        e.c    = c;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse(bit u, bit d);
        up   = u;
        down = d;
        tick();
        up   = 1'b0;
        down = 1'b0;
        tick();
    endtask

    task automatic set_month(int t);
        sel = SEL_M;
        while (cur_m != t) begin
            pulse(1'b1, 1'b0);
            cur_m = (cur_m == 12) ? 1 : cur_m + 1;
        end
        expect_st("set_month", 1, cur_m, cur_y, leap_of(cur_y), 1'b0);
        tick();
    endtask

    task automatic set_year(int t);
        int dup;
        sel = SEL_Y;
        dup = (t - cur_y + 10000) % 10000;
        if (dup <= 5000) repeat (dup) pulse(1'b1, 1'b0);
        else repeat (10000 - dup) pulse(1'b0, 1'b1);
        cur_y = t;
        expect_st("set_year", 1, cur_m, cur_y, leap_of(cur_y), 1'b0);
        tick();
    endtask

    initial begin
        tbl[0] = '{"cnt_nov",  11, 2023, 12, 2023, 1'b0, 1'b0};
        tbl[1] = '{"cnt_dec",  12, 2023,  1, 2024, 1'b1, 1'b0};
        tbl[2] = '{"cnt_9999", 12, 9999,  1,    0, 1'b1, 1'b1};
        tbl[3] = '{"cnt_may",   5, 1900,  6, 1900, 1'b0, 1'b0};
        tbl[4] = '{"cnt_2099", 12, 2099,  1, 2100, 1'b0, 1'b0};
        tbl[5] = '{"cnt_2399", 12, 2399,  1, 2400, 1'b1, 1'b0};

        rst_n = 1'b0; en_1 = 1'b0; carry_in = 1'b0;
        up = 1'b0; down = 1'b0; sel = SEL_N;
        @(negedge clk);
        expect_st("reset", 1, 1, 2000, 1'b1, 1'b0);
        tick();
        rst_n = 1'b1;
        expect_st("reset_hold", 1, 1, 2000, 1'b1, 1'b0);
        tick();
        cur_m = 1;
        cur_y = 2000;

        // Count vectors
        for (int i = 0; i < 6; i++) begin
            set_month(tbl[i].m0);
            set_year(tbl[i].y0);
            sel = SEL_N; en_1 = 1'b1; carry_in = 1'b1;
            expect_st(tbl[i].name, 1, tbl[i].m1, tbl[i].y1, tbl[i].l1, tbl[i].c1);
            tick();
            carry_in = 1'b0;
            expect_st({tbl[i].name, "_next"}, 1, tbl[i].m1, tbl[i].y1, tbl[i].l1, 1'b0);
            tick();
            cur_m = tbl[i].m1;
            cur_y = tbl[i].y1;
        end

        // Count disabled
        sel = SEL_N; en_1 = 1'b0; carry_in = 1'b1;
        expect_st("en_off", 1, cur_m, cur_y, leap_of(cur_y), 1'b0);
        tick();
        carry_in = 1'b0; en_1 = 1'b1;

        // Year edits
        set_year(1900);
        expect_st("yr_1900_up", 2, cur_m, 1901, 1'b0, 1'b0);
        pulse(1'b1, 1'b0); cur_y = 1901;
        set_year(1899);
        expect_st("yr_1899_up", 2, cur_m, 1900, 1'b0, 1'b0);
        pulse(1'b1, 1'b0); cur_y = 1900;
        set_year(2000);
        expect_st("yr_2000", 1, cur_m, 2000, 1'b1, 1'b0);
        tick();
        set_year(0);
        expect_st("yr_0_down", 2, cur_m, 9999, 1'b0, 1'b0);
        pulse(1'b0, 1'b1); cur_y = 9999;
        expect_st("yr_9999_up", 2, cur_m, 0, 1'b1, 1'b0);
        expect_st("yr_wrap_nocarry", 3, cur_m, 0, 1'b1, 1'b0);
        pulse(1'b1, 1'b0); tick(); cur_y = 0;
        up = 1'b1;
        expect_st("yr_latency_pre", 1, cur_m, 0, 1'b1, 1'b0);
        tick();
        up = 1'b0;
        expect_st("yr_latency_post", 1, cur_m, 1, 1'b0, 1'b0);
        tick(); cur_y = 1;

        // Month edits
        set_month(1);
        expect_st("mo_1_down", 2, 12, cur_y, leap_of(cur_y), 1'b0);
        pulse(1'b0, 1'b1); cur_m = 12;
        expect_st("mo_12_up", 2, 1, cur_y, leap_of(cur_y), 1'b0);
        pulse(1'b1, 1'b0); cur_m = 1;
        expect_st("mo_both", 2, cur_m, cur_y, leap_of(cur_y), 1'b0);
        expect_st("mo_both_after", 3, cur_m, cur_y, leap_of(cur_y), 1'b0);
        pulse(1'b1, 1'b1); tick();
        en_1 = 1'b1; carry_in = 1'b1;
        expect_st("mo_carry_ignored", 1, cur_m, cur_y, leap_of(cur_y), 1'b0);
        tick();
        sel = SEL_Y;
        expect_st("yr_carry_ignored", 1, cur_m, cur_y, leap_of(cur_y), 1'b0);
        tick();
        carry_in = 1'b0;

        // Keys outside edit mode
        sel = SEL_N;
        expect_st("key_no_edit", 2, cur_m, cur_y, leap_of(cur_y), 1'b0);
        pulse(1'b1, 1'b0);
        up = 1'b1;
        tick();
        sel = SEL_M;
        expect_st("key_tracked", 1, cur_m, cur_y, leap_of(cur_y), 1'b0);
        expect_st("key_tracked2", 2, cur_m, cur_y, leap_of(cur_y), 1'b0);
        tick(); tick();
        up = 1'b0;
        tick();

        // Reset over an edit step in flight
        sel = SEL_Y; up = 1'b1;
        tick();
        up = 1'b0; rst_n = 1'b0;
        expect_st("rst_edit", 1, 1, 2000, 1'b1, 1'b0);
        tick();
        rst_n = 1'b1;
        expect_st("rst_edit_after", 1, 1, 2000, 1'b1, 1'b0);
        tick();
        cur_m = 1; cur_y = 2000;

        // Reset over a count step
        set_month(7);
        sel = SEL_N; en_1 = 1'b1; carry_in = 1'b1; rst_n = 1'b0;
        expect_st("rst_count", 1, 1, 2000, 1'b1, 1'b0);
        tick();
        rst_n = 1'b1; carry_in = 1'b0;
        expect_st("rst_count_after", 1, 1, 2000, 1'b1, 1'b0);
        tick();
        cur_m = 1;

        // Held key from month 1 for six cycles
        sel = SEL_M; up = 1'b1;
        repeat (6) tick();
        up = 1'b0;
`ifdef KEY_REPEAT_EN
        cur_m = 5;
`else
        cur_m = 2;
`endif
        expect_st("hold_6", 1, cur_m, cur_y, leap_of(cur_y), 1'b0);
        tick();
        expect_st("hold_6_after", 1, cur_m, cur_y, leap_of(cur_y), 1'b0);
        tick();

        repeat (4) tick();
        while (sb.size() > 0) begin
            mon_e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL %s unchecked: due %0d now %0d", mon_e.name, mon_e.due, cyc);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
